// File: rtl/av2_deblock_edge_filter.sv
// AV2 narrow (filter4) deblocking core: LANES edge lines per beat, 2-stage pipeline,
// valid/ready on both sides, start/done job framing with a saturating filtered-lane count.

module av2_deblock_edge_filter_lane #(
  parameter int PIX_W = 10,
  parameter int W     = PIX_W + 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               bypass,
  input  logic [W-1:0]       lim,
  input  logic [W-1:0]       blim,
  input  logic [W-1:0]       thr,
  input  logic [4*PIX_W-1:0] pix_in,
  output logic [4*PIX_W-1:0] pix_out,
  output logic               flt
);
  localparam logic signed [W-1:0] OFS  = W'(1 << (PIX_W-1));
  localparam logic signed [W-1:0] MAXV = W'((1 << (PIX_W-1)) - 1);
  localparam logic signed [W-1:0] MINV = W'(-(1 << (PIX_W-1)));
  localparam logic signed [W-1:0] C1 = W'(1);
  localparam logic signed [W-1:0] C3 = W'(3);
  localparam logic signed [W-1:0] C4 = W'(4);

  function automatic logic [W-1:0] absd(input logic [PIX_W-1:0] a, input logic [PIX_W-1:0] b);
    return (a > b) ? W'(a - b) : W'(b - a);
  endfunction

  function automatic logic signed [W-1:0] clamp(input logic signed [W-1:0] x);
    if (x > MAXV) return MAXV;
    if (x < MINV) return MINV;
    return x;
  endfunction

  function automatic logic signed [W-1:0] sx(input logic [PIX_W-1:0] x);
    return $signed(W'(x)) - OFS;
  endfunction

  function automatic logic [PIX_W-1:0] ux(input logic signed [W-1:0] x);
    return PIX_W'(x + OFS);
  endfunction

  // S1: edge activity measures
  logic [PIX_W-1:0] p1, p0, q0, q1;
  logic [W-1:0]     dp, dq, d0, d1;
  logic             mask, hev;

  assign {q1, q0, p0, p1} = pix_in;
  assign dp   = absd(p1, p0);
  assign dq   = absd(q1, q0);
  assign d0   = absd(p0, q0);
  assign d1   = absd(p1, q1);
  assign mask = (dp <= lim) && (dq <= lim) && (((d0 << 1) + (d1 >> 1)) <= blim);
  assign hev  = (dp > thr) || (dq > thr);

  logic [4*PIX_W-1:0] s1_pix;
  logic               s1_flt, s1_hev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_pix <= '0;
      s1_flt <= 1'b0;
      s1_hev <= 1'b0;
    end else if (en) begin
      s1_pix <= pix_in;
      s1_flt <= mask && !bypass;
      s1_hev <= hev;
    end
  end

  // S2: filter4 in the signed (offset-removed) domain
  logic signed [W-1:0] sp1, sp0, sq0, sq1, d3, f0, f, f1, f2, g;
  logic [4*PIX_W-1:0]  filt;

  always_comb begin
    sp1  = sx(s1_pix[PIX_W-1:0]);
    sp0  = sx(s1_pix[2*PIX_W-1:PIX_W]);
    sq0  = sx(s1_pix[3*PIX_W-1:2*PIX_W]);
    sq1  = sx(s1_pix[4*PIX_W-1:3*PIX_W]);
    d3   = sq0 - sp0;
    f0   = s1_hev ? clamp(sp1 - sq1) : '0;
    f    = clamp(f0 + d3 + d3 + d3);
    f1   = clamp(f + C4) >>> 3;
    f2   = clamp(f + C3) >>> 3;
    g    = (f1 + C1) >>> 1;
    filt = s1_pix;
    filt[3*PIX_W-1:2*PIX_W] = ux(clamp(sq0 - f1));
    filt[2*PIX_W-1:PIX_W]   = ux(clamp(sp0 + f2));
    if (!s1_hev) begin
      filt[4*PIX_W-1:3*PIX_W] = ux(clamp(sq1 - g));
      filt[PIX_W-1:0]         = ux(clamp(sp1 + g));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_out <= '0;
      flt     <= 1'b0;
    end else if (en) begin
      pix_out <= s1_flt ? filt : s1_pix;
      flt     <= s1_flt;
    end
  end
endmodule

module av2_deblock_edge_filter #(
  parameter int PIX_W = 10,
  parameter int LANES = 4,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [CNT_W-1:0]         num_beats,
  input  logic [5:0]               filter_level,
  input  logic [2:0]               sharpness,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [LANES*4*PIX_W-1:0] s_pix,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [LANES*4*PIX_W-1:0] m_pix,
  output logic                     busy,
  output logic                     done,
  output logic [CNT_W-1:0]         filt_cnt
);
  localparam int W      = PIX_W + 4;
  localparam int QW     = 4 * PIX_W;
  localparam int STAGES = 2;

  logic [5:0]        level;
  logic [2:0]        sh;
  logic [CNT_W-1:0]  nb, in_cnt, out_cnt;
  logic [STAGES:1]   vld_pipe;
  logic [LANES-1:0]  flt;
  logic              stall, acc, out_hs, start_ok;

  assign stall    = vld_pipe[STAGES] && !m_ready;
  assign s_ready  = busy && (in_cnt < nb) && !stall;
  assign acc      = s_valid && s_ready;
  assign m_valid  = vld_pipe[STAGES];
  assign out_hs   = m_valid && m_ready;
  assign start_ok = start && !busy && !done;

  // Thresholds derived in the 8-bit domain, then scaled to PIX_W
  logic [1:0]   shamt;
  logic [7:0]   lim8, blim8, thr8;
  logic [W-1:0] lim, blim, thr;

  always_comb begin
    shamt = 2'(sh != 3'd0) + 2'(sh > 3'd4);
    lim8  = {2'b0, level} >> shamt;
    if (sh != 3'd0 && lim8 > (8'd9 - 8'(sh))) lim8 = 8'd9 - 8'(sh);
    if (lim8 == 8'd0) lim8 = 8'd1;
    blim8 = (({2'b0, level} + 8'd2) << 1) + lim8;
    thr8  = {2'b0, level} >> 4;
  end

  assign lim  = W'(lim8)  << (PIX_W - 8);
  assign blim = W'(blim8) << (PIX_W - 8);
  assign thr  = W'(thr8)  << (PIX_W - 8);

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    av2_deblock_edge_filter_lane #(.PIX_W(PIX_W)) u_lane (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (!stall),
      .bypass  (level == 6'd0),
      .lim     (lim),
      .blim    (blim),
      .thr     (thr),
      .pix_in  (s_pix[i*QW +: QW]),
      .pix_out (m_pix[i*QW +: QW]),
      .flt     (flt[i])
    );
  end

  logic [CNT_W:0]   fsum;
  logic [CNT_W-1:0] filt_next;

  always_comb begin
    fsum = {1'b0, filt_cnt};
    for (int i = 0; i < LANES; i++) fsum = fsum + (CNT_W+1)'(flt[i]);
    filt_next = fsum[CNT_W] ? '1 : fsum[CNT_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      level    <= '0;
      sh       <= '0;
      nb       <= '0;
      in_cnt   <= '0;
      out_cnt  <= '0;
      filt_cnt <= '0;
    end else begin
      if (!stall) vld_pipe <= {vld_pipe[STAGES-1:1], acc};
      done <= 1'b0;
      if (start_ok) begin
        level    <= filter_level;
        sh       <= sharpness;
        nb       <= num_beats;
        in_cnt   <= '0;
        out_cnt  <= '0;
        filt_cnt <= '0;
        busy     <= (num_beats != '0);
        done     <= (num_beats == '0);
      end else if (busy) begin
        if (acc) in_cnt <= in_cnt + CNT_W'(1);
        if (out_hs) begin
          out_cnt  <= out_cnt + CNT_W'(1);
          filt_cnt <= filt_next;
          // last output of the job closes it
          if (out_cnt == nb - CNT_W'(1)) begin
            busy <= 1'b0;
            done <= 1'b1;
          end
        end
      end
    end
  end
endmodule
